// File: rtl/acc_flag_widen_multi_if.sv
// Control, per-channel flag and sample pass-through signals of the ACC flag widening stage.
// master drives the controls and samples; slave is the widening/combine stage.
interface acc_flag_widen_multi_if #(
  parameter int unsigned CH_NUM   = 3,
  parameter int unsigned CNT_WID  = 16,
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned SEL_WID  = 2
);
  logic                laser_start_i;
  logic                filter_en_i;
  logic                single_track_i;
  logic [SEL_WID-1:0]  single_ch_sel_i;
  logic                retrig_mode_i;
  logic [CNT_WID-1:0]  detect_width_para_i;
  logic [CH_NUM-1:0]   ch_result_i;
  logic [CH_NUM-1:0]   ch_invert_i;
  logic [CH_NUM-1:0]   ch_bypass_i;
  logic                filter_vld_i;
  logic [DATA_WID-1:0] filter_data_i;
  logic [CH_NUM-1:0]   widen_result_o;
  logic                filter_vld_o;
  logic [DATA_WID-1:0] filter_data_o;
  logic                acc_result_o;
  logic [CNT_WID-1:0]  acc_event_cnt_o;

  modport master (
    output laser_start_i, filter_en_i, single_track_i, single_ch_sel_i, retrig_mode_i,
           detect_width_para_i, ch_result_i, ch_invert_i, ch_bypass_i,
           filter_vld_i, filter_data_i,
    input  widen_result_o, filter_vld_o, filter_data_o, acc_result_o, acc_event_cnt_o
  );

  modport slave (
    input  laser_start_i, filter_en_i, single_track_i, single_ch_sel_i, retrig_mode_i,
           detect_width_para_i, ch_result_i, ch_invert_i, ch_bypass_i,
           filter_vld_i, filter_data_i,
    output widen_result_o, filter_vld_o, filter_data_o, acc_result_o, acc_event_cnt_o
  );
endinterface

// File: rtl/acc_flag_widen_multi.sv
// N-channel detect-pulse widening, ACC combine with edge counter, and
// sample pass-through delayed to stay aligned with the ACC result.
module acc_flag_widen_multi #(
  parameter int unsigned CH_NUM   = 3,
  parameter int unsigned CNT_WID  = 16,
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned SEL_WID  = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  acc_flag_widen_multi_if.slave bus
);

  typedef enum logic {IDLE, WIDEN} state_t;

  localparam logic [CNT_WID-1:0] ONE = CNT_WID'(1);

  state_t              state     [CH_NUM];
  state_t              state_nxt [CH_NUM];
  logic [CNT_WID-1:0]  cnt       [CH_NUM];
  logic [CNT_WID-1:0]  cnt_nxt   [CH_NUM];
  logic [CNT_WID-1:0]  width_eff;
  logic [CH_NUM-1:0]   widen;
  logic [CH_NUM-1:0]   term;
  logic                sel_bit;
  logic                acc_nxt;
  logic                acc_q;
  logic [CNT_WID-1:0]  event_cnt;
  logic [1:0]          vld_d;
  logic [DATA_WID-1:0] data_d1;
  logic [DATA_WID-1:0] data_d2;

  assign width_eff = (bus.detect_width_para_i == '0) ? ONE : bus.detect_width_para_i;

  // Exit uses >= so a width lowered below the running count ends on the next valid sample.
  always_comb begin
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      state_nxt[k] = state[k];
      cnt_nxt[k]   = cnt[k];
      if (!bus.filter_en_i) begin
        state_nxt[k] = IDLE;
        cnt_nxt[k]   = '0;
      end else begin
        case (state[k])
          IDLE: begin
            if (bus.ch_result_i[k]) begin
              state_nxt[k] = WIDEN;
              cnt_nxt[k]   = '0;
            end
          end
          WIDEN: begin
            if (bus.ch_result_i[k] && bus.retrig_mode_i) begin
              cnt_nxt[k] = '0;
            end else if (bus.filter_vld_i) begin
              if (cnt[k] >= width_eff - ONE) begin
                state_nxt[k] = IDLE;
                cnt_nxt[k]   = '0;
              end else begin
                cnt_nxt[k] = cnt[k] + ONE;
              end
            end
          end
          default: begin
            state_nxt[k] = IDLE;
            cnt_nxt[k]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (rst_i) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
      end else begin
        state[k] <= state_nxt[k];
        cnt[k]   <= cnt_nxt[k];
      end
    end
  end

  always_comb begin
    widen   = '0;
    sel_bit = 1'b0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      widen[k] = (state[k] == WIDEN);
      if (bus.single_ch_sel_i == SEL_WID'(k)) sel_bit = (state[k] == WIDEN);
    end
    term    = bus.ch_bypass_i | (widen ^ bus.ch_invert_i);
    acc_nxt = 1'b0;
    if (!bus.laser_start_i)      acc_nxt = 1'b0;
    else if (bus.single_track_i) acc_nxt = sel_bit;
    else if (bus.filter_en_i)    acc_nxt = &term;
  end

  // Counter moves on the same edge acc_q rises, so both become visible together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= 1'b0;
      event_cnt <= '0;
      vld_d     <= '0;
      data_d1   <= '0;
      data_d2   <= '0;
    end else begin
      acc_q   <= acc_nxt;
      vld_d   <= {vld_d[0], bus.filter_vld_i};
      data_d1 <= bus.filter_data_i;
      data_d2 <= data_d1;
      if (!bus.laser_start_i)
        event_cnt <= '0;
      else if (acc_nxt && !acc_q && (event_cnt != '1))
        event_cnt <= event_cnt + ONE;
    end
  end

  assign bus.widen_result_o  = widen;
  assign bus.acc_result_o    = acc_q;
  assign bus.acc_event_cnt_o = event_cnt;
  assign bus.filter_vld_o    = vld_d[1];
  assign bus.filter_data_o   = data_d2;

endmodule

// File: tb/tb_acc_flag_widen_multi.sv
// Random-stimulus bench for acc_flag_widen_multi with a behavioural model feeding
// a scoreboard queue that a negedge monitor drains.
module tb_acc_flag_widen_multi;
  localparam int unsigned CH = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [CH-1:0] widen;
    logic          vld;
    logic [DW-1:0] data;
    logic          acc;
    int            cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  acc_flag_widen_multi_if #(.CH_NUM(CH), .CNT_WID(CW), .DATA_WID(DW), .SEL_WID(SW)) bus ();

  acc_flag_widen_multi #(.CH_NUM(CH), .CNT_WID(CW), .DATA_WID(DW), .SEL_WID(SW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Reference model: a channel is "active" from the trigger until it has seen W valid samples.
  bit            active [CH];
  int            seen   [CH];
  bit            m_acc;
  int            m_cnt;
  bit            v1, v2;
  logic [DW-1:0] d1, d2;

  task automatic model_step();
    bit new_acc;
    bit all_ok;
    int w;
    int sel;
    if (rst) begin
      for (int k = 0; k < CH; k++) begin active[k] = 0; seen[k] = 0; end
      m_acc = 0; m_cnt = 0; v1 = 0; v2 = 0; d1 = '0; d2 = '0;
      return;
    end
    sel = int'(bus.single_ch_sel_i);
    all_ok = 1;
    for (int k = 0; k < CH; k++)
      if (!(bus.ch_bypass_i[k] || (active[k] != bus.ch_invert_i[k]))) all_ok = 0;
    if (!bus.laser_start_i)      new_acc = 0;
    else if (bus.single_track_i) new_acc = (sel < CH) ? active[sel] : 0;
    else if (bus.filter_en_i)    new_acc = all_ok;
    else                         new_acc = 0;
    if (!bus.laser_start_i) m_cnt = 0;
    else if (new_acc && !m_acc && m_cnt < CNT_MAX) m_cnt++;
    m_acc = new_acc;
    w = (bus.detect_width_para_i == '0) ? 1 : int'(bus.detect_width_para_i);
    for (int k = 0; k < CH; k++) begin
      if (!bus.filter_en_i) begin
        active[k] = 0;
      end else if (!active[k]) begin
        if (bus.ch_result_i[k]) begin active[k] = 1; seen[k] = 0; end
      end else if (bus.ch_result_i[k] && bus.retrig_mode_i) begin
        seen[k] = 0;
      end else if (bus.filter_vld_i) begin
        seen[k]++;
        if (seen[k] >= w) active[k] = 0;
      end
    end
    d2 = d1; d1 = bus.filter_data_i;
    v2 = v1; v1 = bus.filter_vld_i;
  endtask

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < CH; k++) e.widen[k] = active[k];
    e.vld = v2; e.data = d2; e.acc = m_acc; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("widen", int'(bus.widen_result_o), int'(e.widen));
      chk("vld_o", int'(bus.filter_vld_o), int'(e.vld));
      chk("data_o", int'(bus.filter_data_o), int'(e.data));
      chk("acc", int'(bus.acc_result_o), int'(e.acc));
      chk("event_cnt", int'(bus.acc_event_cnt_o), e.cnt);
    end
  end

  task automatic idle_inputs();
    bus.laser_start_i       = 1'b1;
    bus.filter_en_i         = 1'b1;
    bus.single_track_i      = 1'b0;
    bus.single_ch_sel_i     = '0;
    bus.retrig_mode_i       = 1'b0;
    bus.detect_width_para_i = CW'(3);
    bus.ch_result_i         = '0;
    bus.ch_invert_i         = '0;
    bus.ch_bypass_i         = '0;
    bus.filter_vld_i        = 1'b1;
    bus.filter_data_i       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    push_expected();
    #1;
  endtask

  task automatic random_inputs();
    rst                     = ($urandom_range(0, 199) == 0);
    bus.laser_start_i       = ($urandom_range(0, 39) != 0);
    bus.filter_en_i         = ($urandom_range(0, 29) != 0);
    bus.single_track_i      = ($urandom_range(0, 3) == 0);
    bus.single_ch_sel_i     = SW'($urandom_range(0, 3));
    bus.retrig_mode_i       = $urandom_range(0, 1) == 1;
    bus.detect_width_para_i = CW'($urandom_range(0, 5));
    for (int k = 0; k < CH; k++) begin
      bus.ch_result_i[k] = ($urandom_range(0, 5) == 0);
      bus.ch_invert_i[k] = ($urandom_range(0, 3) == 0);
      bus.ch_bypass_i[k] = ($urandom_range(0, 2) == 0);
    end
    bus.filter_vld_i  = ($urandom_range(0, 3) != 0);
    bus.filter_data_i = DW'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;

    // Directed: W=3, constant vld, single ch0 pulse, retrigger on and off.
    for (int r = 0; r < 2; r++) begin
      bus.retrig_mode_i = (r == 1);
      bus.ch_result_i = 3'b001; tick();
      bus.ch_result_i = 3'b000; tick();
      bus.ch_result_i = 3'b001; tick();
      bus.ch_result_i = 3'b000;
      repeat (8) tick();
    end

    // Directed: invert ch2, pulse ch0 and ch1 together.
    bus.ch_invert_i = 3'b100;
    bus.ch_result_i = 3'b011; tick();
    bus.ch_result_i = 3'b000;
    repeat (6) tick();
    bus.ch_invert_i = 3'b000;

    for (int i = 0; i < 2000; i++) begin
      random_inputs();
      tick();
    end

    // Saturation: clear the counter, then toggle the all-bypass term for 20+ rising edges.
    idle_inputs();
    rst = 1'b0;
    bus.laser_start_i = 1'b0;
    repeat (2) tick();
    bus.laser_start_i = 1'b1;
    for (int j = 0; j < 96; j++) begin
      bus.ch_bypass_i = ((j % 4) < 2) ? '1 : '0;
      tick();
    end
    @(negedge clk);
    chk("sat_cnt", int'(bus.acc_event_cnt_o), CNT_MAX);

    bus.laser_start_i = 1'b0;
    tick();
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
